// File: rtl/ram_rd_pkg.sv
// Shared state encoding and sizing helpers for the RAM read streamer.
package ram_rd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

   localparam int RAM_LAT_NO_OREG = 1;
   localparam int RAM_LAT_OREG    = 2;

   // One slot per in-flight read plus two for the stream-side slack.
   function automatic int fifo_depth(input int lat);
      return lat + 2;
   endfunction

endpackage

// File: rtl/ram_rd_skid_fifo.sv
// Small register FIFO holding {last, data} beats between the RAM read pipe and the stream port.
module ram_rd_skid_fifo #(
   parameter int WIDTH  = 33,
   parameter int DEPTH  = 3,
   parameter int CWIDTH = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [WIDTH-1:0]  push_data,
   input  logic              pop,
   output logic [WIDTH-1:0]  pop_data,
   output logic [CWIDTH-1:0] count,
   output logic              empty,
   output logic              full
);

   localparam int PWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0]  mem_reg [DEPTH];
   logic [PWIDTH-1:0] wr_ptr_reg;
   logic [PWIDTH-1:0] rd_ptr_reg;
   logic [CWIDTH-1:0] count_reg;
   logic              do_push;
   logic              do_pop;

   function automatic logic [PWIDTH-1:0] ptr_inc(input logic [PWIDTH-1:0] p);
      return (p == PWIDTH'(DEPTH - 1)) ? '0 : p + PWIDTH'(1);
   endfunction

   assign empty    = (count_reg == '0);
   assign full     = (count_reg == CWIDTH'(DEPTH));
   assign count    = count_reg;
   assign pop_data = mem_reg[rd_ptr_reg];
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
            wr_ptr_reg          <= ptr_inc(wr_ptr_reg);
         end
         if (do_pop) begin
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CWIDTH'(1);
            2'b01:   count_reg <= count_reg - CWIDTH'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/ram_rd_streamer.sv
// Drains {start address, word count} from a block RAM read port into a valid/ready stream.
// Optional stall statistic enabled by defining RAM_RD_STREAMER_STATS_EN.
module ram_rd_streamer
   import ram_rd_pkg::*;
#(
   parameter int DWIDTH      = 32,
   parameter int AWIDTH      = 8,
   parameter int LWIDTH      = 16,
   parameter int RAM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [AWIDTH-1:0] cmd_addr,
   input  logic [LWIDTH-1:0] cmd_len,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   output logic              ram_en,
   output logic              ram_we,
   output logic [AWIDTH-1:0] ram_addr,
   input  logic [DWIDTH-1:0] ram_dout,
   output logic [DWIDTH-1:0] o_tdata,
   output logic              o_tvalid,
   output logic              o_tlast,
   input  logic              o_tready,
   output logic              busy,
   output logic              done,
   output logic [31:0]       stall_cnt
);

   localparam int FIFO_DEPTH = fifo_depth(RAM_LATENCY);
   localparam int CWIDTH     = $clog2(FIFO_DEPTH + 1);

   rd_state_t         state_reg, state_next;
   logic [AWIDTH-1:0] addr_reg, addr_next;
   logic [LWIDTH-1:0] remaining_reg, remaining_next;
   logic [AWIDTH-1:0] last_addr_reg;
   logic              done_reg, done_next;
   logic [RAM_LATENCY-1:0] pipe_vld_reg;
   logic [RAM_LATENCY-1:0] pipe_last_reg;

   logic              issue;
   logic              credit_ok;
   logic [CWIDTH-1:0] inflight;
   logic [CWIDTH-1:0] fifo_count;
   logic              fifo_empty;
   logic              fifo_full;
   logic [DWIDTH:0]   fifo_head;
   logic              handshake;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RAM_LATENCY; i++) begin
         inflight = inflight + CWIDTH'(pipe_vld_reg[i]);
      end
   end

   // Reserve a FIFO slot for every read still travelling through the RAM.
   assign credit_ok = !fifo_full &&
                      (({1'b0, fifo_count} + {1'b0, inflight}) < (CWIDTH + 1)'(FIFO_DEPTH));

   assign handshake = o_tvalid && o_tready;

   always_comb begin
      state_next     = state_reg;
      addr_next      = addr_reg;
      remaining_next = remaining_reg;
      done_next      = 1'b0;
      issue          = 1'b0;
      cmd_ready      = 1'b0;
      case (state_reg)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               addr_next      = cmd_addr;
               remaining_next = cmd_len;
               if (cmd_len == '0) begin
                  done_next = 1'b1;
               end else begin
                  state_next = RUN;
               end
            end
         end
         RUN: begin
            if (credit_ok) begin
               issue          = 1'b1;
               addr_next      = addr_reg + AWIDTH'(1);
               remaining_next = remaining_reg - LWIDTH'(1);
               if (remaining_reg == LWIDTH'(1)) begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (handshake && o_tlast) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         addr_reg      <= '0;
         remaining_reg <= '0;
         last_addr_reg <= '0;
         done_reg      <= 1'b0;
         pipe_vld_reg  <= '0;
         pipe_last_reg <= '0;
      end else begin
         state_reg        <= state_next;
         addr_reg         <= addr_next;
         remaining_reg    <= remaining_next;
         last_addr_reg    <= ram_addr;
         done_reg         <= done_next;
         pipe_vld_reg[0]  <= issue;
         pipe_last_reg[0] <= issue && (remaining_reg == LWIDTH'(1));
         for (int i = 1; i < RAM_LATENCY; i++) begin
            pipe_vld_reg[i]  <= pipe_vld_reg[i-1];
            pipe_last_reg[i] <= pipe_last_reg[i-1];
         end
      end
   end

   // Idle read cycles re-present the previous address so the RAM sees a stable bus.
   assign ram_addr = issue ? addr_reg : last_addr_reg;
   assign ram_we   = 1'b0;
   assign busy     = (state_reg != IDLE);
   assign done     = done_reg;

   generate
      if (RAM_LATENCY == RAM_LAT_OREG) begin : g_en_oreg
         // The output register shares the enable, so it must clock every cycle.
         assign ram_en = busy;
      end else begin : g_en_noreg
         assign ram_en = issue;
      end
   endgenerate

   ram_rd_skid_fifo #(
      .WIDTH  (DWIDTH + 1),
      .DEPTH  (FIFO_DEPTH),
      .CWIDTH (CWIDTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (pipe_vld_reg[RAM_LATENCY-1]),
      .push_data ({pipe_last_reg[RAM_LATENCY-1], ram_dout}),
      .pop       (o_tready),
      .pop_data  (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign o_tvalid = !fifo_empty;
   assign o_tdata  = fifo_head[DWIDTH-1:0];
   assign o_tlast  = o_tvalid && fifo_head[DWIDTH];

`ifdef RAM_RD_STREAMER_STATS_EN
   logic [31:0] stall_cnt_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_reg <= '0;
      end else if (cmd_valid && cmd_ready) begin
         stall_cnt_reg <= '0;
      end else if (o_tvalid && !o_tready && (stall_cnt_reg != '1)) begin
         stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_reg;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Directed bench for ram_rd_streamer: one instance with RAM_LATENCY=1, one with RAM_LATENCY=2.
module tb_ram_rd_streamer;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam int LW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic [AW-1:0] cmd_addr;
   logic [LW-1:0] cmd_len;
   logic          cmd_valid;
   logic          o_tready;
   logic          sel;

   logic          cmd_ready_a, ram_en_a, ram_we_a, o_tvalid_a, o_tlast_a, busy_a, done_a;
   logic [AW-1:0] ram_addr_a;
   logic [DW-1:0] ram_dout_a, o_tdata_a;
   logic [31:0]   stall_cnt_a;
   logic          cmd_ready_b, ram_en_b, ram_we_b, o_tvalid_b, o_tlast_b, busy_b, done_b;
   logic [AW-1:0] ram_addr_b;
   logic [DW-1:0] ram_dout_b, o_tdata_b, ram_q_b;
   logic [31:0]   stall_cnt_b;

   ram_rd_streamer #(.DWIDTH(DW), .AWIDTH(AW), .LWIDTH(LW), .RAM_LATENCY(1)) u_dut_a (
      .clk(clk), .reset(reset), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .cmd_valid(cmd_valid && !sel), .cmd_ready(cmd_ready_a), .ram_en(ram_en_a),
      .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_dout(ram_dout_a), .o_tdata(o_tdata_a),
      .o_tvalid(o_tvalid_a), .o_tlast(o_tlast_a), .o_tready(o_tready), .busy(busy_a),
      .done(done_a), .stall_cnt(stall_cnt_a)
   );

   ram_rd_streamer #(.DWIDTH(DW), .AWIDTH(AW), .LWIDTH(LW), .RAM_LATENCY(2)) u_dut_b (
      .clk(clk), .reset(reset), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .cmd_valid(cmd_valid && sel), .cmd_ready(cmd_ready_b), .ram_en(ram_en_b),
      .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_dout(ram_dout_b), .o_tdata(o_tdata_b),
      .o_tvalid(o_tvalid_b), .o_tlast(o_tlast_b), .o_tready(o_tready), .busy(busy_b),
      .done(done_b), .stall_cnt(stall_cnt_b)
   );

   // RAM models preloaded with mem[i] = i
   logic [DW-1:0] mem [256];
   initial for (int i = 0; i < 256; i++) mem[i] = 32'(i);

   always @(posedge clk) if (ram_en_a) ram_dout_a <= mem[ram_addr_a];
   always @(posedge clk) if (ram_en_b) begin
      ram_q_b    <= mem[ram_addr_b];
      ram_dout_b <= ram_q_b;
   end

   // Selected-instance view
   logic          v_ready, v_en, v_valid, v_last, v_done;
   logic [DW-1:0] v_data;
   assign v_ready = sel ? cmd_ready_b : cmd_ready_a;
   assign v_en    = sel ? ram_en_b    : ram_en_a;
   assign v_valid = sel ? o_tvalid_b  : o_tvalid_a;
   assign v_last  = sel ? o_tlast_b   : o_tlast_a;
   assign v_done  = sel ? done_b      : done_a;
   assign v_data  = sel ? o_tdata_b   : o_tdata_a;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
      int            c;
   } beat_t;

   int    cyc = 0;
   beat_t beats[$];
   int    acc_q[$];
   int    vld_q[$];
   int    done_cnt = 0;
   int    done_cyc = 0;
   int    en_cnt = 0;
   int    stall_tot = 0;
   int    max_fc_b = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset) begin
         if (cmd_valid && v_ready) acc_q.push_back(cyc);
         if (v_valid) vld_q.push_back(cyc);
         if (v_valid && o_tready) beats.push_back('{v_data, v_last, cyc});
         if (v_valid && !o_tready) stall_tot++;
         if (v_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (v_en) en_cnt++;
         if (int'(u_dut_b.fifo_count) > max_fc_b) max_fc_b = int'(u_dut_b.fifo_count);
      end
   end

   int checks = 0;
   int failures = 0;
   bit bp_mode = 1'b0;
   int bp_k = 0;

   task automatic tick();
      @(posedge clk);
      #1;
      if (bp_mode) begin
         o_tready = (bp_k % 3 == 0);
         bp_k++;
      end
   endtask

   task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
      int n0;
      n0 = acc_q.size();
      cmd_addr  = a;
      cmd_len   = l;
      cmd_valid = 1'b1;
      for (int i = 0; i < 100 && acc_q.size() == n0; i++) tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int target, input int bound);
      for (int i = 0; i < bound && done_cnt < target; i++) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; o_tready = 1'b1; sel = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({cmd_ready_a, ram_en_a, ram_we_a, o_tvalid_a, o_tlast_a, busy_a, done_a} !== 7'b1000000) begin
         failures++;
         $display("FAIL reset_ctrl_a got=%b exp=1000000",
                  {cmd_ready_a, ram_en_a, ram_we_a, o_tvalid_a, o_tlast_a, busy_a, done_a});
      end
      checks++;
      if ({cmd_ready_b, ram_en_b, ram_we_b, o_tvalid_b, o_tlast_b, busy_b, done_b} !== 7'b1000000) begin
         failures++;
         $display("FAIL reset_ctrl_b got=%b exp=1000000",
                  {cmd_ready_b, ram_en_b, ram_we_b, o_tvalid_b, o_tlast_b, busy_b, done_b});
      end
      checks++;
      if (ram_addr_a !== 8'h00 || o_tdata_a !== 32'h0 || stall_cnt_a !== 32'h0) begin
         failures++;
         $display("FAIL reset_data_a addr=%h data=%h stall=%h exp all zero", ram_addr_a, o_tdata_a, stall_cnt_a);
      end
      checks++;
      if (ram_addr_b !== 8'h00 || o_tdata_b !== 32'h0 || stall_cnt_b !== 32'h0) begin
         failures++;
         $display("FAIL reset_data_b addr=%h data=%h stall=%h exp all zero", ram_addr_b, o_tdata_b, stall_cnt_b);
      end
      reset = 1'b0;
      tick(); tick();
      checks++;
      if (cmd_ready_a !== 1'b1 || busy_a !== 1'b0 || o_tvalid_a !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_idle ready=%b busy=%b valid=%b exp 1 0 0", cmd_ready_a, busy_a, o_tvalid_a);
      end
      $display("reset: done");
   endtask

   task automatic test_basic();
      int b0, v0, a0, d0, e0, acc;
      sel = 1'b0; o_tready = 1'b1; tick();
      b0 = beats.size(); v0 = vld_q.size(); a0 = acc_q.size(); d0 = done_cnt; e0 = en_cnt;
      send_cmd(8'h10, 16'd4);
      wait_done(d0 + 1, 60);
      acc = (acc_q.size() > a0) ? acc_q[a0] : -1000;
      checks++;
      if (beats.size() - b0 != 4 || done_cnt != d0 + 1) begin
         failures++;
         $display("FAIL basic_count beats=%0d done=%0d exp 4 1", beats.size() - b0, done_cnt - d0);
      end
      for (int i = 0; i < 4; i++) begin
         if (beats.size() > b0 + i) begin
            checks++;
            if (beats[b0+i].d !== 32'h10 + 32'(i) || beats[b0+i].l !== (i == 3) || beats[b0+i].c != acc + 3 + i) begin
               failures++;
               $display("FAIL basic_beat%0d data=%h last=%b cyc=%0d exp %h %b %0d", i,
                        beats[b0+i].d, beats[b0+i].l, beats[b0+i].c - acc, 32'h10 + 32'(i), i == 3, 3 + i);
            end
         end
      end
      checks++;
      if (vld_q.size() <= v0 || vld_q[v0] != acc + 3) begin
         failures++;
         $display("FAIL basic_latency first_valid=%0d exp 3", (vld_q.size() > v0) ? vld_q[v0] - acc : -1);
      end
      checks++;
      if (done_cyc != acc + 7) begin
         failures++;
         $display("FAIL basic_done_cycle got=%0d exp 7", done_cyc - acc);
      end
      checks++;
      if (en_cnt - e0 != 4) begin
         failures++;
         $display("FAIL basic_ram_en got=%0d exp 4", en_cnt - e0);
      end
      $display("basic: addr=10 len=4 beats=%0d", beats.size() - b0);
   endtask

   task automatic test_wrap();
      int b0, d0;
      logic [DW-1:0] exp_d [4];
      exp_d[0] = 32'hFE; exp_d[1] = 32'hFF; exp_d[2] = 32'h00; exp_d[3] = 32'h01;
      sel = 1'b0; o_tready = 1'b1;
      b0 = beats.size(); d0 = done_cnt;
      send_cmd(8'hFE, 16'd4);
      wait_done(d0 + 1, 60);
      checks++;
      if (beats.size() - b0 != 4) begin
         failures++;
         $display("FAIL wrap_count got=%0d exp 4", beats.size() - b0);
      end
      for (int i = 0; i < 4; i++) begin
         if (beats.size() > b0 + i) begin
            checks++;
            if (beats[b0+i].d !== exp_d[i] || beats[b0+i].l !== (i == 3)) begin
               failures++;
               $display("FAIL wrap_beat%0d data=%h last=%b exp %h %b", i, beats[b0+i].d, beats[b0+i].l, exp_d[i], i == 3);
            end
         end
      end
      $display("wrap: addr=FE len=4 beats=%0d", beats.size() - b0);
   endtask

   task automatic test_backpressure();
      int b0, v0, a0, d0, s0, acc, exp_stall;
      sel = 1'b1; o_tready = 1'b1; tick();
      b0 = beats.size(); v0 = vld_q.size(); a0 = acc_q.size(); d0 = done_cnt; s0 = stall_tot;
      bp_k = 0; bp_mode = 1'b1;
      send_cmd(8'h20, 16'd8);
      wait_done(d0 + 1, 300);
      bp_mode = 1'b0; o_tready = 1'b1;
      tick();
      acc = (acc_q.size() > a0) ? acc_q[a0] : -1000;
      checks++;
      if (beats.size() - b0 != 8 || done_cnt != d0 + 1) begin
         failures++;
         $display("FAIL bp_count beats=%0d done=%0d exp 8 1", beats.size() - b0, done_cnt - d0);
      end
      for (int i = 0; i < 8; i++) begin
         if (beats.size() > b0 + i) begin
            checks++;
            if (beats[b0+i].d !== 32'h20 + 32'(i) || beats[b0+i].l !== (i == 7)) begin
               failures++;
               $display("FAIL bp_beat%0d data=%h last=%b exp %h %b", i, beats[b0+i].d, beats[b0+i].l, 32'h20 + 32'(i), i == 7);
            end
         end
      end
      checks++;
      if (vld_q.size() <= v0 || vld_q[v0] != acc + 4) begin
         failures++;
         $display("FAIL bp_latency first_valid=%0d exp 4", (vld_q.size() > v0) ? vld_q[v0] - acc : -1);
      end
      checks++;
      if (max_fc_b > 4) begin
         failures++;
         $display("FAIL bp_fifo_depth max=%0d exp <=4", max_fc_b);
      end
`ifdef RAM_RD_STREAMER_STATS_EN
      exp_stall = stall_tot - s0;
`else
      exp_stall = 0;
`endif
      checks++;
      if (stall_cnt_b !== 32'(exp_stall)) begin
         failures++;
         $display("FAIL bp_stall_cnt got=%0d exp %0d", stall_cnt_b, exp_stall);
      end
      $display("backpressure: len=8 beats=%0d stalls_seen=%0d", beats.size() - b0, stall_tot - s0);
   endtask

   task automatic test_zero_len();
      int b0, v0, a0, d0, e0, acc;
      sel = 1'b0; o_tready = 1'b1;
      b0 = beats.size(); v0 = vld_q.size(); a0 = acc_q.size(); d0 = done_cnt; e0 = en_cnt;
      send_cmd(8'h30, 16'd0);
      repeat (6) tick();
      acc = (acc_q.size() > a0) ? acc_q[a0] : -1000;
      checks++;
      if (beats.size() != b0 || vld_q.size() != v0 || en_cnt != e0) begin
         failures++;
         $display("FAIL zero_no_activity beats=%0d valids=%0d ram_en=%0d exp 0 0 0",
                  beats.size() - b0, vld_q.size() - v0, en_cnt - e0);
      end
      checks++;
      if (done_cnt != d0 + 1 || done_cyc != acc + 1) begin
         failures++;
         $display("FAIL zero_done count=%0d cyc=%0d exp 1 1", done_cnt - d0, done_cyc - acc);
      end
      checks++;
      if (cmd_ready_a !== 1'b1 || busy_a !== 1'b0) begin
         failures++;
         $display("FAIL zero_idle ready=%b busy=%b exp 1 0", cmd_ready_a, busy_a);
      end
      $display("zero_len: done pulses=%0d", done_cnt - d0);
   endtask

   task automatic test_reset_mid();
      int b0, d0;
      sel = 1'b0; o_tready = 1'b1;
      b0 = beats.size(); d0 = done_cnt;
      send_cmd(8'h50, 16'd10);
      for (int i = 0; i < 60 && beats.size() < b0 + 3; i++) tick();
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (o_tvalid_a !== 1'b0 || busy_a !== 1'b0 || ram_en_a !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_async valid=%b busy=%b ram_en=%b exp 0 0 0", o_tvalid_a, busy_a, ram_en_a);
      end
      tick(); tick();
      reset = 1'b0;
      repeat (3) tick();
      checks++;
      if (done_cnt != d0 || o_tvalid_a !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_no_done done=%0d valid=%b exp 0 0", done_cnt - d0, o_tvalid_a);
      end
      b0 = beats.size();
      send_cmd(8'h40, 16'd2);
      wait_done(d0 + 1, 60);
      checks++;
      if (beats.size() - b0 != 2) begin
         failures++;
         $display("FAIL rst_mid_count got=%0d exp 2", beats.size() - b0);
      end else begin
         checks++;
         if (beats[b0].d !== 32'h40 || beats[b0].l !== 1'b0 || beats[b0+1].d !== 32'h41 || beats[b0+1].l !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_data got=%h/%b %h/%b exp 40/0 41/1",
                     beats[b0].d, beats[b0].l, beats[b0+1].d, beats[b0+1].l);
         end
      end
      $display("reset_mid: new cmd beats=%0d", beats.size() - b0);
   endtask

   task automatic test_back_to_back();
      int b0, a0, d0, acc1, acc2;
      logic [DW-1:0] exp_d [5];
      logic          exp_l [5];
      exp_d[0] = 32'h60; exp_d[1] = 32'h61; exp_d[2] = 32'h62; exp_d[3] = 32'h70; exp_d[4] = 32'h71;
      exp_l[0] = 1'b0;   exp_l[1] = 1'b0;   exp_l[2] = 1'b1;   exp_l[3] = 1'b0;   exp_l[4] = 1'b1;
      sel = 1'b0; o_tready = 1'b1;
      b0 = beats.size(); a0 = acc_q.size(); d0 = done_cnt;
      cmd_addr = 8'h60; cmd_len = 16'd3; cmd_valid = 1'b1;
      for (int i = 0; i < 100 && acc_q.size() == a0; i++) tick();
      cmd_addr = 8'h70; cmd_len = 16'd2;
      for (int i = 0; i < 100 && acc_q.size() < a0 + 2; i++) tick();
      cmd_valid = 1'b0;
      wait_done(d0 + 2, 100);
      acc1 = (acc_q.size() > a0) ? acc_q[a0] : -1000;
      acc2 = (acc_q.size() > a0 + 1) ? acc_q[a0+1] : -1000;
      checks++;
      if (acc_q.size() - a0 != 2 || done_cnt - d0 != 2) begin
         failures++;
         $display("FAIL b2b_counts accepts=%0d dones=%0d exp 2 2", acc_q.size() - a0, done_cnt - d0);
      end
      checks++;
      if (acc2 < acc1 + 6) begin
         failures++;
         $display("FAIL b2b_accept_early second_accept=%0d exp >=6", acc2 - acc1);
      end
      checks++;
      if (beats.size() - b0 != 5) begin
         failures++;
         $display("FAIL b2b_beat_count got=%0d exp 5", beats.size() - b0);
      end
      for (int i = 0; i < 5; i++) begin
         if (beats.size() > b0 + i) begin
            checks++;
            if (beats[b0+i].d !== exp_d[i] || beats[b0+i].l !== exp_l[i] ||
                beats[b0+i].c != ((i < 3) ? acc1 + 3 + i : acc2 + i)) begin
               failures++;
               $display("FAIL b2b_beat%0d data=%h last=%b cyc=%0d exp %h %b", i,
                        beats[b0+i].d, beats[b0+i].l, beats[b0+i].c, exp_d[i], exp_l[i]);
            end
         end
      end
      $display("back_to_back: beats=%0d second_accept_offset=%0d", beats.size() - b0, acc2 - acc1);
   endtask

   initial begin
      sel = 1'b0;
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero_len();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
